// File: rtl/wb_stage_rf_if.sv
// Bus between the MEM stage and the writeback/register-file block.
// The master drives MEM results, control and read addresses; the slave returns WB state and read data.
interface wb_stage_rf_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned CNTW  = 32
);
    localparam int unsigned AW = $clog2(NREGS);

    logic                      in_valid;
    logic [XLEN-1:0]           in_pc;
    logic [XLEN-1:0]           in_res;
    logic [AW-1:0]             in_rd;
    logic                      in_w_rd;
    logic                      in_w_cr;
    logic [1:0]                in_cmp_res;
    logic                      stall;
    logic                      flush;
    logic [NRD-1:0][AW-1:0]    rd_addr;
    logic [NRD-1:0][XLEN-1:0]  rd_data;
    logic                      out_valid;
    logic [XLEN-1:0]           out_pc;
    logic [XLEN-1:0]           out_res;
    logic [AW-1:0]             out_rd;
    logic                      out_w_rd;
    logic [1:0]                cmp_reg;
    logic [CNTW-1:0]           retired;

    modport master (
        output in_valid, in_pc, in_res, in_rd, in_w_rd, in_w_cr, in_cmp_res,
               stall, flush, rd_addr,
        input  rd_data, out_valid, out_pc, out_res, out_rd, out_w_rd, cmp_reg, retired
    );

    modport slave (
        input  in_valid, in_pc, in_res, in_rd, in_w_rd, in_w_cr, in_cmp_res,
               stall, flush, rd_addr,
        output rd_data, out_valid, out_pc, out_res, out_rd, out_w_rd, cmp_reg, retired
    );
endinterface

// File: rtl/wb_stage_rf.sv
// br32 writeback stage: one-entry WB register committing into a multi-read-port
// register file, plus the compare register and a retired-instruction counter.
module wb_stage_rf #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned NRD     = 2,
    parameter int unsigned ZERO_R0 = 1,
    parameter int unsigned CNTW    = 32
) (
    input  logic         clk,
    input  logic         rst,
    wb_stage_rf_if.slave bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic            wb_valid;
    logic [XLEN-1:0] wb_pc;
    logic [XLEN-1:0] wb_res;
    logic [AW-1:0]   wb_rd;
    logic            wb_w_rd;     // already qualified with valid
    logic [1:0]      cmp_q;
    logic [CNTW-1:0] retired_q;
    logic            commit_c;
    logic            take_c;
    logic [NRD-1:0][XLEN-1:0] rd_data_c;

    assign take_c   = bus.in_valid && !bus.flush;
    assign commit_c = wb_valid && !bus.stall;

    // WB register capture, commit into the register file, cmp_reg and retire count
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_pc     <= '0;
            wb_res    <= '0;
            wb_rd     <= '0;
            wb_w_rd   <= 1'b0;
            cmp_q     <= 2'b00;
            retired_q <= '0;
            regs      <= '{default: '0};
        end else begin
            if (!bus.stall) begin
                wb_valid <= take_c;
                wb_pc    <= bus.in_pc;
                wb_res   <= bus.in_res;
                wb_rd    <= bus.in_rd;
                wb_w_rd  <= take_c && bus.in_w_rd;
                if (take_c && bus.in_w_cr) begin
                    cmp_q <= bus.in_cmp_res;
                end
            end
            if (commit_c) begin
                retired_q <= retired_q + CNTW'(1);
                if (wb_w_rd && !((ZERO_R0 != 0) && (wb_rd == AW'(0)))) begin
                    regs[wb_rd] <= wb_res;
                end
            end
        end
    end

    // Read ports: hard zero, then bypass of the pending WB write, then the array
    always_comb begin
        rd_data_c = '0;
        for (int p = 0; p < NRD; p++) begin
            if ((ZERO_R0 != 0) && (bus.rd_addr[p] == AW'(0))) begin
                rd_data_c[p] = '0;
            end else if (wb_w_rd && (bus.rd_addr[p] == wb_rd)) begin
                rd_data_c[p] = wb_res;
            end else begin
                rd_data_c[p] = regs[bus.rd_addr[p]];
            end
        end
    end

    assign bus.rd_data   = rd_data_c;
    assign bus.out_valid = wb_valid;
    assign bus.out_pc    = wb_pc;
    assign bus.out_res   = wb_res;
    assign bus.out_rd    = wb_rd;
    assign bus.out_w_rd  = wb_w_rd;
    assign bus.cmp_reg   = cmp_q;
    assign bus.retired   = retired_q;
endmodule

// File: tb/tb_wb_stage_rf.sv
// Directed bench for wb_stage_rf: dut0 has r0 hardwired to zero, dut1 does not;
// both see identical stimulus.
module tb_wb_stage_rf;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 3;
    localparam int unsigned CNTW  = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    wb_stage_rf_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .CNTW(CNTW)) b0 ();
    wb_stage_rf_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .CNTW(CNTW)) b1 ();

    wb_stage_rf #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_R0(1), .CNTW(CNTW)) dut0 (
        .clk(clk), .rst(rst), .bus(b0.slave)
    );
    wb_stage_rf #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_R0(0), .CNTW(CNTW)) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );

    assign b1.in_valid   = b0.in_valid;
    assign b1.in_pc      = b0.in_pc;
    assign b1.in_res     = b0.in_res;
    assign b1.in_rd      = b0.in_rd;
    assign b1.in_w_rd    = b0.in_w_rd;
    assign b1.in_w_cr    = b0.in_w_cr;
    assign b1.in_cmp_res = b0.in_cmp_res;
    assign b1.stall      = b0.stall;
    assign b1.flush      = b0.flush;
    assign b1.rd_addr    = b0.rd_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic v, input logic [4:0] rd, input logic [31:0] res,
                           input logic wrd, input logic wcr, input logic [1:0] cmp,
                           input logic [31:0] pc);
        b0.in_valid   = v;
        b0.in_rd      = rd;
        b0.in_res     = res;
        b0.in_w_rd    = wrd;
        b0.in_w_cr    = wcr;
        b0.in_cmp_res = cmp;
        b0.in_pc      = pc;
    endtask

    task automatic idle();
        set_mem(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic read_all(input logic [4:0] a);
        for (int p = 0; p < NRD; p++) b0.rd_addr[p] = a;
        #1;
    endtask

    task automatic check_ports0(input string tag, input logic [31:0] exp);
        for (int p = 0; p < NRD; p++) check($sformatf("%s_p%0d", tag, p), 64'(b0.rd_data[p]), 64'(exp));
    endtask

    task automatic check_ports1(input string tag, input logic [31:0] exp);
        for (int p = 0; p < NRD; p++) check($sformatf("%s_p%0d", tag, p), 64'(b1.rd_data[p]), 64'(exp));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        b0.stall = 1'b0;
        b0.flush = 1'b0;

        // Reset with random inputs
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            set_mem(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 1'($urandom),
                    2'($urandom), $urandom);
            b0.stall = 1'($urandom);
            b0.flush = 1'($urandom);
            for (int p = 0; p < NRD; p++) b0.rd_addr[p] = 5'($urandom);
            step();
        end
        rst = 1'b0;
        b0.stall = 1'b0;
        b0.flush = 1'b0;
        idle();
        check("rst_out_valid", 64'(b0.out_valid), 64'd0);
        check("rst_out_w_rd", 64'(b0.out_w_rd), 64'd0);
        check("rst_cmp_reg", 64'(b0.cmp_reg), 64'd0);
        check("rst_retired", 64'(b0.retired), 64'd0);
        check("rst_retired1", 64'(b1.retired), 64'd0);
        read_all(5'd5);
        check_ports0("rst_rd5", 32'h0);
        read_all(5'd31);
        check_ports0("rst_rd31", 32'h0);
        read_all(5'd0);
        check_ports1("rst_rd0_nz", 32'h0);

        // Basic writeback with bypass, then commit
        set_mem(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 2'd0, 32'h100);
        step();
        idle();
        read_all(5'd5);
        check("basic_out_valid", 64'(b0.out_valid), 64'd1);
        check("basic_out_pc", 64'(b0.out_pc), 64'h100);
        check("basic_out_rd", 64'(b0.out_rd), 64'd5);
        check("basic_out_res", 64'(b0.out_res), 64'hDEADBEEF);
        check("basic_out_w_rd", 64'(b0.out_w_rd), 64'd1);
        check("basic_retired_pre", 64'(b0.retired), 64'd0);
        check_ports0("basic_bypass", 32'hDEADBEEF);
        step();
        check("basic_out_valid_post", 64'(b0.out_valid), 64'd0);
        check("basic_retired_post", 64'(b0.retired), 64'd1);
        check_ports0("basic_regfile", 32'hDEADBEEF);

        // Stall holds the entry; a different MEM entry is presented but not taken
        set_mem(1'b1, 5'd7, 32'h1234, 1'b1, 1'b0, 2'd0, 32'h104);
        step();
        b0.stall = 1'b1;
        set_mem(1'b1, 5'd8, 32'h99, 1'b1, 1'b1, 2'd3, 32'h108);
        read_all(5'd7);
        check("stall_bypass_0", 64'(b0.rd_data[0]), 64'h1234);
        check("stall_retired_0", 64'(b0.retired), 64'd1);
        for (int c = 1; c <= 3; c++) begin
            b0.flush = (c == 2);
            step();
            check($sformatf("stall_bypass_%0d", c), 64'(b0.rd_data[2]), 64'h1234);
            check($sformatf("stall_retired_%0d", c), 64'(b0.retired), 64'd1);
            check($sformatf("stall_valid_%0d", c), 64'(b0.out_valid), 64'd1);
            check($sformatf("stall_rd_%0d", c), 64'(b0.out_rd), 64'd7);
        end
        b0.stall = 1'b0;
        b0.flush = 1'b0;
        idle();
        step();
        check("stall_retired_drop", 64'(b0.retired), 64'd2);
        check("stall_out_valid", 64'(b0.out_valid), 64'd0);
        check("stall_cmp_untouched", 64'(b0.cmp_reg), 64'd0);
        check_ports0("stall_regfile", 32'h1234);
        step();
        check("stall_once_only", 64'(b0.retired), 64'd2);
        read_all(5'd8);
        check_ports0("stall_not_taken", 32'h0);

        // Flush squashes the entry; the same entry unflushed writes cmp after 1 edge
        set_mem(1'b1, 5'd3, 32'h55, 1'b1, 1'b1, 2'd2, 32'h10C);
        b0.flush = 1'b1;
        step();
        b0.flush = 1'b0;
        idle();
        read_all(5'd3);
        check("flush_out_valid", 64'(b0.out_valid), 64'd0);
        check("flush_out_w_rd", 64'(b0.out_w_rd), 64'd0);
        check("flush_cmp", 64'(b0.cmp_reg), 64'd0);
        step();
        check("flush_retired", 64'(b0.retired), 64'd2);
        check_ports0("flush_rd3", 32'h0);
        set_mem(1'b1, 5'd3, 32'h55, 1'b1, 1'b1, 2'd2, 32'h10C);
        step();
        idle();
        check("noflush_cmp", 64'(b0.cmp_reg), 64'd2);
        check("noflush_out_valid", 64'(b0.out_valid), 64'd1);
        step();
        check("noflush_retired", 64'(b0.retired), 64'd3);
        check_ports0("noflush_rd3", 32'h55);
        set_mem(1'b0, 5'd4, 32'h77, 1'b1, 1'b1, 2'd1, 32'h110);
        step();
        idle();
        check("bubble_cmp", 64'(b0.cmp_reg), 64'd2);
        check("bubble_out_valid", 64'(b0.out_valid), 64'd0);
        step();
        check("bubble_retired", 64'(b0.retired), 64'd3);

        // Register 0: hardwired in dut0, ordinary in dut1
        set_mem(1'b1, 5'd0, 32'hFFFF, 1'b1, 1'b0, 2'd0, 32'h114);
        step();
        idle();
        read_all(5'd0);
        check_ports0("r0_zero_bypass", 32'h0);
        check_ports1("r0_plain_bypass", 32'hFFFF);
        step();
        check_ports0("r0_zero_reg", 32'h0);
        check_ports1("r0_plain_reg", 32'hFFFF);
        check("r0_zero_array", 64'(dut0.regs[0]), 64'h0);
        check("r0_retired0", 64'(b0.retired), 64'd4);
        check("r0_retired1", 64'(b1.retired), 64'd4);

        // Back-to-back writes to the same register
        set_mem(1'b1, 5'd9, 32'd1, 1'b1, 1'b0, 2'd0, 32'h118);
        step();
        set_mem(1'b1, 5'd9, 32'd2, 1'b1, 1'b0, 2'd0, 32'h11C);
        read_all(5'd9);
        check_ports0("b2b_first", 32'd1);
        step();
        idle();
        read_all(5'd9);
        check_ports0("b2b_second", 32'd2);
        check("b2b_mid_retired", 64'(b0.retired), 64'd5);
        step();
        check_ports0("b2b_final", 32'd2);
        check("b2b_retired", 64'(b0.retired), 64'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
